apb_cmd_master: RTL and testbench

- APB3 requester that sits directly upstream of the student subsystem toplevel and drives its APB slave port (PADDR/PSEL/PENABLE/PWRITE/PWDATA; consumes PRDATA/PREADY/PSLVERR).
- Converts a simple valid/ready command stream (from a test harness or SoC interconnect stub) into single APB transfers.
- Returns each result on a valid/ready response channel.
- Adds a bus-timeout watchdog and misalignment checking, so a hung or erroring slave never stalls the requester.

---
 rtl/apb_cmd_pkg.sv | 30 +++
 rtl/apb_timeout_cnt.sv | 32 +++
 rtl/apb_cmd_master.sv | 142 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command requester and its watchdog.
package apb_cmd_pkg;

  localparam int unsigned DEF_AW = 10;
  localparam int unsigned DEF_DW = 32;

  // Byte-offset bits that must be zero for a word-aligned access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DW-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

  // Watchdog counter width; floored at one bit so a disabled watchdog still elaborates.
  function automatic int unsigned wd_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase watchdog; expired_c flags the last allowed wait cycle.
module apb_timeout_cnt
  import apb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_in,
  input  logic reset_int,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned CW = wd_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = '1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_c = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: turns valid/ready commands into single APB transfers and
// returns one response per command, with misalignment and timeout protection.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned APB_AW         = DEF_AW,
  parameter int unsigned APB_DW         = DEF_DW,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_in,
  input  logic              reset_int,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [APB_AW-1:0] req_addr,
  input  logic [APB_DW-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [APB_AW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  state_e            state_q;
  logic [APB_AW-1:0] paddr_q;
  logic [APB_DW-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  rsp_t              rsp_q;

  logic wd_clear;
  logic wd_en;
  logic wd_expired;

  assign wd_clear = (state_q == ST_SETUP);
  assign wd_en    = (state_q == ST_ACCESS);

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_in   (clk_in),
    .reset_int(reset_int),
    .clear_i  (wd_clear),
    .en_i     (wd_en),
    .expired_c(wd_expired)
  );

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            pwrite_q    <= req_write;
            paddr_q     <= req_addr;
            pwdata_q    <= req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            // Misaligned commands complete locally without touching the bus.
            if ((req_addr[1:0] & ALIGN_MASK) != 2'b00) begin
              rsp_q       <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              psel_q  <= 1'b1;
              state_q <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // PREADY takes priority over a watchdog expiry in the same cycle.
          if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q.rdata <= (pwrite_q || PSLVERR) ? '0 : DEF_DW'(PRDATA);
            rsp_q.err   <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (wd_expired) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_q       <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = APB_DW'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PADDR       = paddr_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with the watchdog shortened to 8 cycles.
module tb_apb_cmd_master;

  logic        clk_in;
  logic        reset_int;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [9:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int n_cmp;
  int n_bad;

  apb_cmd_master #(
    .APB_AW(10),
    .APB_DW(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_in     (clk_in),
    .reset_int  (reset_int),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .busy       (busy),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one command for a single accepting edge; returns at cycle t+1.
  task automatic issue(input logic wr, input logic [9:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_int = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    #3;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    #20 reset_int = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Zero-wait write.
    PREADY = 1'b1;
    issue(1'b1, 10'h010, 32'hDEADBEEF);
    chk("wr_t1_psel", 32'(PSEL), 32'd1);
    chk("wr_t1_penable", 32'(PENABLE), 32'd0);
    chk("wr_t1_req_ready", 32'(req_ready), 32'd0);
    chk("wr_t1_busy", 32'(busy), 32'd1);
    tick();
    chk("wr_t2_penable", 32'(PENABLE), 32'd1);
    chk("wr_t2_paddr", 32'(PADDR), 32'h010);
    chk("wr_t2_pwdata", PWDATA, 32'hDEADBEEF);
    chk("wr_t2_pwrite", 32'(PWRITE), 32'd1);
    tick();
    PREADY = 1'b0;
    chk("wr_t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_t3_err", 32'(rsp_err), 32'd0);
    chk("wr_t3_rdata", rsp_rdata, 32'd0);
    chk("wr_t3_psel", 32'(PSEL), 32'd0);
    consume("wr");

    // Read with three wait states.
    issue(1'b0, 10'h020, 32'h0);
    chk("rd_t1_setup", {30'd0, PSEL, PENABLE}, 32'b10);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rd_penable_held", 32'(PENABLE), 32'd1);
      chk("rd_paddr_stable", 32'(PADDR), 32'h020);
      chk("rd_pwrite_stable", 32'(PWRITE), 32'd0);
      chk("rd_no_early_rsp", 32'(rsp_valid), 32'd0);
      if (i == 3) begin
        PREADY = 1'b1;
        PRDATA = 32'h12345678;
      end
      tick();
    end
    PREADY = 1'b0;
    PRDATA = 32'h0;
    chk("rd_t6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_t6_rdata", rsp_rdata, 32'h12345678);
    chk("rd_t6_err", 32'(rsp_err), 32'd0);
    chk("rd_t6_penable", 32'(PENABLE), 32'd0);
    consume("rd");

    // Slave error, response held under back-pressure.
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hCAFEF00D;
    issue(1'b0, 10'h024, 32'h0);
    tick();
    tick();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("err_rsp_err", 32'(rsp_err), 32'd1);
      chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("err_rdata", rsp_rdata, 32'd0);
      chk("err_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    consume("err");

    // Timeout: PREADY never arrives.
    issue(1'b0, 10'h030, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_access", {30'd0, PSEL, PENABLE}, 32'b11);
      tick();
    end
    chk("to_psel_drop", {30'd0, PSEL, PENABLE}, 32'b00);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    consume("to");

    // PREADY on the last allowed cycle completes normally.
    issue(1'b0, 10'h034, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        PREADY = 1'b1;
        PRDATA = 32'hA5A5_0001;
      end
      tick();
    end
    PREADY = 1'b0;
    chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("edge_err", 32'(rsp_err), 32'd0);
    chk("edge_timeout", 32'(rsp_timeout), 32'd0);
    chk("edge_rdata", rsp_rdata, 32'hA5A5_0001);
    consume("edge");

    // Command after timeout proceeds normally.
    PREADY = 1'b1;
    issue(1'b1, 10'h044, 32'h0BAD_F00D);
    tick();
    chk("post_to_pwdata", PWDATA, 32'h0BAD_F00D);
    tick();
    PREADY = 1'b0;
    chk("post_to_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'b100);
    consume("post_to");

    // Misaligned address completes without bus activity.
    issue(1'b1, 10'h013, 32'h1111_2222);
    chk("mis_psel", 32'(PSEL), 32'd0);
    chk("mis_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'b110);
    chk("mis_rdata", rsp_rdata, 32'd0);
    consume("mis");

    // Asynchronous reset during ACCESS.
    issue(1'b0, 10'h050, 32'h0);
    tick();
    chk("rst_mid_access", {30'd0, PSEL, PENABLE}, 32'b11);
    #2 reset_int = 1'b0;
    #1;
    chk("rst_mid_psel", {30'd0, PSEL, PENABLE}, 32'b00);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    #10 reset_int = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_after_req_ready", 32'(req_ready), 32'd1);
      chk("rst_after_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_after_psel", 32'(PSEL), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
